// File: rtl/dmi_req_buffer.sv
// DMI access buffer: queues synchronized DMI strobes in a FIFO and replays them to the
// debug module one request at a time, capturing read responses into rd_data.
module dmi_req_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [6:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  input  logic        dmi_reset,
  output logic        dmi_req_valid,
  output logic        dmi_req_write,
  output logic [6:0]  dmi_req_addr,
  output logic [31:0] dmi_req_wdata,
  input  logic        dmi_req_ready,
  input  logic        dmi_rsp_valid,
  input  logic [31:0] dmi_rsp_rdata,
  output logic [31:0] rd_data,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e        state_q, state_d;
  logic [39:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_write_q, req_write_d;
  logic [6:0]    req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;

  logic          full, pop, push, drop;
  logic [39:0]   head;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    full = (count_q == FullCnt);
    pop  = (state_q == StIdle) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
    drop = reg_en && full && !pop;
    push = reg_en && !drop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rd_data_d   = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          req_write_d = head[39];
          req_addr_d  = head[38:32];
          req_wdata_d = head[31:0];
          state_d     = StReq;
        end
      end
      StReq: begin
        if (dmi_req_ready) state_d = req_write_q ? StIdle : StWait;
      end
      StWait: begin
        if (dmi_rsp_valid) begin
          rd_data_d = dmi_rsp_rdata;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (dmi_reset) overflow_d = 1'b0;
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {reg_wr_en, reg_wr_addr, reg_wr_data};
  end

  assign dmi_req_valid = (state_q == StReq);
  assign dmi_req_write = req_write_q;
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_wdata = req_wdata_q;
  assign rd_data       = rd_data_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dmi_req_buffer.sv
// Bench for dmi_req_buffer: queue-based reference model with a request scoreboard and
// per-cycle monitor, driven by directed scenarios followed by random traffic.
module tb_dmi_req_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_en, reg_wr_en;
  logic [6:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        dmi_reset;
  logic        dmi_req_valid, dmi_req_write;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_wdata;
  logic        dmi_req_ready, dmi_rsp_valid;
  logic [31:0] dmi_rsp_rdata, rd_data;
  logic        overflow, busy;

  always #5 clk = ~clk;

  dmi_req_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .reg_en(reg_en), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .dmi_reset(dmi_reset),
    .dmi_req_valid(dmi_req_valid), .dmi_req_write(dmi_req_write),
    .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
    .dmi_req_ready(dmi_req_ready), .dmi_rsp_valid(dmi_rsp_valid),
    .dmi_rsp_rdata(dmi_rsp_rdata), .rd_data(rd_data), .overflow(overflow), .busy(busy)
  );

  typedef struct packed {logic wr; logic [6:0] addr; logic [31:0] data;} ent_t;

  ent_t        m_fifo[$];
  ent_t        exp_req_q[$];
  ent_t        m_cur;
  ent_t        sb_e;
  int          m_phase;  // 0: nothing in flight, 1: request presented, 2: awaiting read data
  logic [31:0] m_rd;
  logic        m_ovf, m_busy;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    exp_req_q.delete();
    m_cur   = '0;
    m_phase = 0;
    m_rd    = '0;
    m_ovf   = 1'b0;
    m_busy  = 1'b0;
  endfunction

  function automatic void model_step();
    bit   pop, drop;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    pop  = (m_phase == 0) && (m_fifo.size() > 0);
    drop = reg_en && (m_fifo.size() == DEPTH) && !pop;
    case (m_phase)
      0:       if (pop) begin m_cur = m_fifo.pop_front(); m_phase = 1; end
      1:       if (dmi_req_ready) m_phase = m_cur.wr ? 0 : 2;
      default: if (dmi_rsp_valid) begin m_rd = dmi_rsp_rdata; m_phase = 0; end
    endcase
    if (reg_en && !drop) begin
      e = {reg_wr_en, reg_wr_addr, reg_wr_data};
      m_fifo.push_back(e);
      exp_req_q.push_back(e);
    end
    if (drop) m_ovf = 1'b1;
    else if (dmi_reset) m_ovf = 1'b0;
    m_busy = (m_phase != 0) || (m_fifo.size() != 0);
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push_in(input bit wr, input logic [6:0] a, input logic [31:0] d);
    reg_en = 1'b1; reg_wr_en = wr; reg_wr_addr = a; reg_wr_data = d;
  endtask

  task automatic quiet();
    reg_en = 1'b0; reg_wr_en = 1'b0; dmi_rsp_valid = 1'b0; dmi_reset = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_valid", 40'(dmi_req_valid), 40'(m_phase == 1));
      chk("req_fields", {dmi_req_write, dmi_req_addr, dmi_req_wdata}, m_cur);
      chk("rd_data", 40'(rd_data), 40'(m_rd));
      chk("overflow", 40'(overflow), 40'(m_ovf));
      chk("busy", 40'(busy), 40'(m_busy));
      if (dmi_req_valid && dmi_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_req: got request %h required none", {dmi_req_write, dmi_req_addr,
                   dmi_req_wdata});
        end else begin
          sb_e = exp_req_q.pop_front();
          chk("sb_req", {dmi_req_write, dmi_req_addr, dmi_req_wdata}, sb_e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    quiet();
    reg_wr_addr = '0; reg_wr_data = '0; dmi_req_ready = 1'b0; dmi_rsp_rdata = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Single write with ready tied high.
    dmi_req_ready = 1'b1;
    push_in(1'b1, 7'h10, 32'hDEADBEEF); step();
    quiet(); repeat (4) step();

    // Read, response three cycles after the handshake, then a spurious response in idle.
    push_in(1'b0, 7'h11, 32'h0); step();
    quiet(); repeat (2) step();
    dmi_req_ready = 1'b0; repeat (2) step();
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h12345678; step();
    quiet(); step();
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'hFFFFFFFF; step();
    quiet(); step();

    // Overflow: ready low, DEPTH+2 pushes, then dmi_reset with and without a drop.
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_in(1'b1, 7'(i), 32'hA000_0000 + 32'(i)); step();
    end
    quiet(); step();
    push_in(1'b1, 7'h7F, 32'hBAD0BAD0); dmi_reset = 1'b1; step();
    quiet(); step();
    dmi_reset = 1'b1; step();
    quiet(); step();
    dmi_req_ready = 1'b1; repeat (12) step();

    // Full FIFO with the FSM idle: push lands in the same cycle as the pop.
    dmi_req_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_in(1'b1, 7'(8 + i), 32'hC000_0000 + 32'(i)); step();
    end
    quiet(); dmi_req_ready = 1'b1; step();
    dmi_req_ready = 1'b0; push_in(1'b1, 7'h20, 32'hCAFEF00D); step();
    quiet(); step();
    dmi_req_ready = 1'b1; repeat (14) step();

    // Reset while waiting for read data with two entries queued.
    push_in(1'b0, 7'h30, 32'h0); step();
    push_in(1'b1, 7'h31, 32'h1111); step();
    push_in(1'b1, 7'h32, 32'h2222); step();
    quiet(); step();
    do_reset();
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'hAAAA5555; step();
    quiet(); step();
    chk("rd_data_after_reset", 40'(rd_data), 40'h0);

    // Random traffic; second half pushes hard against a mostly stalled consumer.
    for (int i = 0; i < 3000; i++) begin
      reg_en        = ($urandom_range(99) < ((i < 1500) ? 40 : 70));
      reg_wr_en     = 1'($urandom);
      reg_wr_addr   = 7'($urandom);
      reg_wr_data   = $urandom;
      dmi_req_ready = ($urandom_range(99) < ((i < 1500) ? 60 : 20));
      dmi_rsp_valid = ($urandom_range(99) < 30);
      dmi_rsp_rdata = $urandom;
      dmi_reset     = ($urandom_range(99) < 5);
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    quiet();
    dmi_req_ready = 1'b1; dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h5A5A5A5A;
    repeat (30) step();
    chk("sb_drained", 40'(exp_req_q.size()), 40'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_req_buffer.md
# dmi_req_buffer

Core-clock-domain buffer sitting directly downstream of the JTAG-to-core DMI synchronizer, one instance per core. Captures each synchronized DMI access (`reg_en`/`reg_wr_en` strobe with address and write data) into a small FIFO and replays it to the debug module over a valid/ready request channel. Read responses from the debug module are held in a register that drives `rd_data` back to the JTAG TAP. Overflow is reported as a sticky error, cleared by the TAP's DMI reset.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `clk`  in  1  core clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reg_en`  in  1  one-cycle access strobe from the synchronizer.
- `reg_wr_en`  in  1  write qualifier; sampled only when `reg_en`=1.
- `reg_wr_addr`  in  7  DMI register address.
- `reg_wr_data`  in  32  DMI write data; captured for reads too, don't-care downstream.
- `dmi_reset`  in  1  level from the TAP; clears `overflow` while high.
- `dmi_req_valid`  out  1  request valid to the debug module.
- `dmi_req_write`  out  1  1=write, 0=read.
- `dmi_req_addr`  out  7  request address.
- `dmi_req_wdata`  out  32  request write data.
- `dmi_req_ready`  in  1  debug module accepts the request.
- `dmi_rsp_valid`  in  1  read response strobe.
- `dmi_rsp_rdata`  in  32  read response data.
- `rd_data`  out  32  last read response, to TAP `rd_data`.
- `overflow`  out  1  sticky: an access was dropped.
- `busy`  out  1  state≠IDLE or FIFO not empty.

## Operation
- FIFO entry is 40 bits: {write, addr[6:0], wdata[31:0]}. Occupancy counter width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push when `reg_en`=1. `reg_wr_en` without `reg_en` is ignored.
- If a push arrives while the FIFO is full and no pop happens the same cycle, the entry is dropped, contents are unchanged, and `overflow` is set.
- Push and pop in the same cycle: count is unchanged. This is legal even when full, because the pop frees the slot.
- Request FSM, three states:
  - IDLE: if FIFO is non-empty, pop the head into the request output registers and go to REQ. Otherwise stay.
  - REQ: `dmi_req_valid`=1, and all request fields hold stable until `dmi_req_ready`. On valid&ready, go to IDLE for a write and to WAIT for a read.
  - WAIT: on `dmi_rsp_valid`, load `rd_data` from `dmi_rsp_rdata` and go to IDLE.
- `dmi_rsp_valid` in IDLE or REQ is ignored; `rd_data` is unchanged.
- Only one request is outstanding at a time. The FIFO keeps accepting pushes in every state.
- `overflow`:
  - Set on a drop.
  - Cleared on any cycle with `dmi_reset`=1 and no drop.
  - If a drop and `dmi_reset` occur together, set wins.
- `rd_data` changes only on an accepted response, and holds indefinitely otherwise.

## Timing
- Reset: all outputs 0, FIFO empty, pointers 0, state IDLE. Reset asserted mid-transaction abandons the in-flight request and flushes the FIFO. A response arriving after reset is ignored.
- Latency with an empty FIFO and the FSM in IDLE:
  - `reg_en` in cycle N → entry present at N+1 → `dmi_req_valid`=1 at N+2.
  - Write with `dmi_req_ready`=1 at N+2: `dmi_req_valid`=0 at N+3. The next queued entry is presented at N+4 at the earliest.
  - Read: `rd_data` updates the cycle after `dmi_rsp_valid`.
- Back-to-back writes with `dmi_req_ready` tied high: one request per 2 cycles.
- `busy` is registered from next-state/next-count; it deasserts the cycle after the last write handshake or the last read response.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, ready tied 1 → `dmi_req_valid` high only at N+2 with write=1, addr 0x10, wdata 0xDEADBEEF. `rd_data` stays 0. `busy` is 0 from N+3.
- Read addr 0x11, response 0x12345678 three cycles after the handshake → FSM stays in WAIT. `rd_data`=0x12345678 the cycle after `dmi_rsp_valid`. A spurious `dmi_rsp_valid` (data 0xFFFFFFFF) while in IDLE leaves `rd_data` unchanged.
- With `dmi_req_ready`=0, push DEPTH+1 writes (addr 0..4) → the 1st write is popped into REQ, so entries 1..4 fill the FIFO with no drop. A 6th push is dropped and sets `overflow`. Releasing ready drains addr 0,1,2,3,4 in order; the 6th write never appears.
- Hold `overflow`=1, pulse `dmi_reset` → `overflow`=0 next cycle. Repeat with a drop in the same cycle as `dmi_reset` → `overflow` stays 1.
- With the FIFO full, push in the same cycle as an IDLE pop → no drop, count stays DEPTH, order is preserved across the pointer wrap.
- Assert `rst` while in WAIT with 2 entries queued → all outputs 0, `busy`=0. A later `dmi_rsp_valid` (0xAAAA5555) leaves `rd_data`=0.
